// File: rtl/aes_pkg.sv
// Shared AES-128 decrypt definitions: FSM states, round constants,
// GF(2^8) helpers and the forward/inverse S-box tables.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_ROUNDS = 10;

    // Indexed directly by the round counter; entries 0 and 11..15 never used.
    localparam logic [0:15][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] inv_sub_byte(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul09(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] mul0b(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] mul0d(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] mul0e(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse cipher round: InvShiftRows, InvSubBytes,
// AddRoundKey, then InvMixColumns unless this is the last round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last_round,
    output logic [127:0] state_out
);

    // Byte i sits at bits 127-8*i; byte index = 4*column + row.
    logic [7:0] ark [16];

    // Row r rotates right by r columns, then inverse S-box and key add.
    always_comb begin
        ark = '{default: 8'h00};
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                ark[4*c+r] = inv_sub_byte(state_in[127-8*(4*((c-r+4)%4)+r) -: 8])
                             ^ round_key[127-8*(4*c+r) -: 8];
            end
        end
    end

    // Column mixing with {0e,0b,0d,09}, bypassed in the final round.
    always_comb begin
        state_out = '0;
        for (int c = 0; c < 4; c++) begin
            if (last_round) begin
                state_out[127-32*c -: 32] = {ark[4*c], ark[4*c+1], ark[4*c+2], ark[4*c+3]};
            end else begin
                state_out[127-32*c -: 32] = {
                    mul0e(ark[4*c]) ^ mul0b(ark[4*c+1]) ^ mul0d(ark[4*c+2]) ^ mul09(ark[4*c+3]),
                    mul09(ark[4*c]) ^ mul0e(ark[4*c+1]) ^ mul0b(ark[4*c+2]) ^ mul0d(ark[4*c+3]),
                    mul0d(ark[4*c]) ^ mul09(ark[4*c+1]) ^ mul0e(ark[4*c+2]) ^ mul0b(ark[4*c+3]),
                    mul0b(ark[4*c]) ^ mul0d(ark[4*c+1]) ^ mul09(ark[4*c+2]) ^ mul0e(ark[4*c+3])
                };
            end
        end
    end

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 decryptor: one inverse round per clock, starting from
// the final round key and walking the key schedule backwards on the fly.
//
// state | meaning
// IDLE  | waiting for a block, ready=1
// RUN   | applying inverse rounds 10..1, ready=0, valid_in ignored
// DONE  | result just written, valid_out=1 for this single cycle, ready=1
module aes_decrypt_core
    import aes_pkg::*;
#(
    parameter int KEY_WIDTH  = 128,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] ciphertext_in,
    input  logic [KEY_WIDTH-1:0]  key_in,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] plaintext_out,
    output logic [KEY_WIDTH-1:0]  key_out,
    output logic                  valid_out
);

    if (KEY_WIDTH != 128) begin : g_bad_key_width
        $error("aes_decrypt_core: only KEY_WIDTH=128 is supported");
    end
    if (DATA_WIDTH != 128) begin : g_bad_data_width
        $error("aes_decrypt_core: DATA_WIDTH is fixed at 128");
    end

    state_t       fsm;
    logic [3:0]   round;
    logic [127:0] state_reg;
    logic [127:0] key_reg;
    logic [127:0] prev_key;
    logic [127:0] round_out;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  p0, p1, p2, p3;
    logic [31:0]  sub_rot;

    // Undo one key-expansion step: recover round key (round-1) from key_reg.
    always_comb begin
        w0      = key_reg[127:96];
        w1      = key_reg[95:64];
        w2      = key_reg[63:32];
        w3      = key_reg[31:0];
        p3      = w3 ^ w2;
        p2      = w2 ^ w1;
        p1      = w1 ^ w0;
        sub_rot = {sub_byte(p3[23:16]), sub_byte(p3[15:8]),
                   sub_byte(p3[7:0]),   sub_byte(p3[31:24])};
        p0      = w0 ^ sub_rot ^ {RCON[round], 24'h000000};
        prev_key = {p0, p1, p2, p3};
    end

    aes_inv_round u_inv_round (
        .state_in   (state_reg),
        .round_key  (prev_key),
        .last_round (round == 4'd1),
        .state_out  (round_out)
    );

    // Sequencing FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm           <= IDLE;
            round         <= 4'd0;
            state_reg     <= '0;
            key_reg       <= '0;
            plaintext_out <= '0;
            key_out       <= '0;
            valid_out     <= 1'b0;
            ready         <= 1'b1;
        end else begin
            valid_out <= 1'b0;
            case (fsm)
                IDLE, DONE: begin
                    if (valid_in) begin
                        state_reg <= ciphertext_in ^ key_in;
                        key_reg   <= key_in;
                        round     <= 4'(NUM_ROUNDS);
                        fsm       <= RUN;
                        ready     <= 1'b0;
                    end else begin
                        fsm   <= IDLE;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (round == 4'd1) begin
                        plaintext_out <= round_out;
                        key_out       <= prev_key;
                        round         <= 4'd0;
                        fsm           <= DONE;
                        valid_out     <= 1'b1;
                        ready         <= 1'b1;
                    end else begin
                        state_reg <= round_out;
                        key_reg   <= prev_key;
                        round     <= round - 4'd1;
                    end
                end
                default: begin
                    fsm   <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Self-checking bench for aes_decrypt_core. Reference results come from
// published FIPS-197 vectors and a forward AES-128 encryptor written here
// from first principles (S-box derived from GF(2^8) inverses).
module tb_aes_decrypt_core;

    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_KIN = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_KIN  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    // Result visible in the cycle after the 10th edge following accept.
    localparam int LAT = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_in;
    logic [127:0] ciphertext_in;
    logic [127:0] key_in;
    logic         ready;
    logic [127:0] plaintext_out;
    logic [127:0] key_out;
    logic         valid_out;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] sb [256];

    aes_decrypt_core dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .ciphertext_in (ciphertext_in),
        .key_in        (key_in),
        .ready         (ready),
        .plaintext_out (plaintext_out),
        .key_out       (key_out),
        .valid_out     (valid_out)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_encrypt(input logic [127:0] pt, input logic [127:0] key,
                                 output logic [127:0] ct, output logic [127:0] last_key);
        logic [31:0] w [44];
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [31:0] tmp;
        logic [7:0]  rc;
        logic [7:0]  a0, a1, a2, a3;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[4*c+row] = s[4*((c+row)%4)+row];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
                    t[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
        last_key = {w[40], w[41], w[42], w[43]};
    endtask

    // ---------------- stimulus helper ----------------
    // Presents one block at the next falling edge and returns the number of
    // rising edges after the accept edge until valid_out is seen (-1 = never).
    task automatic accept_and_wait(input logic [127:0] ct, input logic [127:0] kin, output int lat);
        @(negedge clk);
        valid_in = 1'b1; ciphertext_in = ct; key_in = kin;
        @(posedge clk); #1;
        valid_in = 1'b0;
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (valid_out === 1'b1) begin lat = k; break; end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", ready); end
        n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid_out: got %b expected 0", valid_out); end
        n_cmp++; if (plaintext_out !== 128'h0) begin n_err++; $display("FAIL reset_plaintext: got %h expected 0", plaintext_out); end
        n_cmp++; if (key_out !== 128'h0) begin n_err++; $display("FAIL reset_key_out: got %h expected 0", key_out); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fips_c1();
        int lat;
        accept_and_wait(C1_CT, C1_KIN, lat);
        n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL c1_latency: got %0d expected %0d", lat, LAT); end
        n_cmp++; if (plaintext_out !== C1_PT) begin n_err++; $display("FAIL c1_plaintext: got %h expected %h", plaintext_out, C1_PT); end
        n_cmp++; if (key_out !== C1_KEY) begin n_err++; $display("FAIL c1_key_out: got %h expected %h", key_out, C1_KEY); end
        @(posedge clk); #1;
        n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL c1_pulse_width: got %b expected 0", valid_out); end
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL c1_ready_idle: got %b expected 1", ready); end
        repeat (3) @(posedge clk); #1;
        n_cmp++; if (plaintext_out !== C1_PT) begin n_err++; $display("FAIL c1_hold: got %h expected %h", plaintext_out, C1_PT); end
    endtask

    task automatic test_fips_b();
        int lat;
        accept_and_wait(B_CT, B_KIN, lat);
        n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL b_latency: got %0d expected %0d", lat, LAT); end
        n_cmp++; if (plaintext_out !== B_PT) begin n_err++; $display("FAIL b_plaintext: got %h expected %h", plaintext_out, B_PT); end
        n_cmp++; if (key_out !== B_KEY) begin n_err++; $display("FAIL b_key_out: got %h expected %h", key_out, B_KEY); end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_back_to_back();
        int lat;
        int gap;
        accept_and_wait(C1_CT, C1_KIN, lat);
        n_cmp++; if (plaintext_out !== C1_PT) begin n_err++; $display("FAIL b2b_first_pt: got %h expected %h", plaintext_out, C1_PT); end
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_done: got %b expected 1", ready); end
        @(negedge clk);
        valid_in = 1'b1; ciphertext_in = B_CT; key_in = B_KIN;
        gap = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (k == 1) valid_in = 1'b0;
            if (valid_out === 1'b1) begin gap = k; break; end
        end
        n_cmp++; if (gap !== LAT + 1) begin n_err++; $display("FAIL b2b_gap: got %0d expected %0d", gap, LAT + 1); end
        n_cmp++; if (plaintext_out !== B_PT) begin n_err++; $display("FAIL b2b_second_pt: got %h expected %h", plaintext_out, B_PT); end
        n_cmp++; if (key_out !== B_KEY) begin n_err++; $display("FAIL b2b_second_key: got %h expected %h", key_out, B_KEY); end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_ignore_in_run();
        int lat;
        int gap;
        int ready_bad;
        ready_bad = 0;
        @(negedge clk);
        valid_in = 1'b1; ciphertext_in = C1_CT; key_in = C1_KIN;
        @(posedge clk); #1;
        @(negedge clk);
        ciphertext_in = B_CT; key_in = B_KIN;
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (valid_out === 1'b1) begin lat = k; break; end
            if (ready !== 1'b0) ready_bad++;
        end
        n_cmp++; if (ready_bad !== 0) begin n_err++; $display("FAIL run_ready_low: got %0d cycles with ready high expected 0", ready_bad); end
        n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL run_first_latency: got %0d expected %0d", lat, LAT); end
        n_cmp++; if (plaintext_out !== C1_PT) begin n_err++; $display("FAIL run_first_pt: got %h expected %h", plaintext_out, C1_PT); end
        n_cmp++; if (key_out !== C1_KEY) begin n_err++; $display("FAIL run_first_key: got %h expected %h", key_out, C1_KEY); end
        gap = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (k == 1) valid_in = 1'b0;
            if (valid_out === 1'b1) begin gap = k; break; end
        end
        n_cmp++; if (gap !== LAT + 1) begin n_err++; $display("FAIL run_second_gap: got %0d expected %0d", gap, LAT + 1); end
        n_cmp++; if (plaintext_out !== B_PT) begin n_err++; $display("FAIL run_second_pt: got %h expected %h", plaintext_out, B_PT); end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int stray;
        @(negedge clk);
        valid_in = 1'b1; ciphertext_in = C1_CT; key_in = C1_KIN;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (plaintext_out !== 128'h0) begin n_err++; $display("FAIL midrst_plaintext: got %h expected 0", plaintext_out); end
        n_cmp++; if (key_out !== 128'h0) begin n_err++; $display("FAIL midrst_key_out: got %h expected 0", key_out); end
        n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL midrst_valid_out: got %b expected 0", valid_out); end
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b expected 1", ready); end
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (valid_out !== 1'b0) stray++;
        end
        n_cmp++; if (stray !== 0) begin n_err++; $display("FAIL midrst_no_pulse: got %0d pulses expected 0", stray); end
        accept_and_wait(C1_CT, C1_KIN, lat);
        n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL midrst_rerun_latency: got %0d expected %0d", lat, LAT); end
        n_cmp++; if (plaintext_out !== C1_PT) begin n_err++; $display("FAIL midrst_rerun_pt: got %h expected %h", plaintext_out, C1_PT); end
        n_cmp++; if (key_out !== C1_KEY) begin n_err++; $display("FAIL midrst_rerun_key: got %h expected %h", key_out, C1_KEY); end
    endtask

    task automatic test_loopback();
        logic [127:0] pt, key, ct, kin;
        int lat;
        int gap;
        for (int n = 0; n < 1000; n++) begin
            pt  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            model_encrypt(pt, key, ct, kin);
            gap = $urandom_range(0, 2);
            repeat (gap) @(posedge clk);
            accept_and_wait(ct, kin, lat);
            n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL loop_latency[%0d]: got %0d expected %0d", n, lat, LAT); end
            n_cmp++; if (plaintext_out !== pt) begin n_err++; $display("FAIL loop_plaintext[%0d]: got %h expected %h", n, plaintext_out, pt); end
            n_cmp++; if (key_out !== key) begin n_err++; $display("FAIL loop_key_out[%0d]: got %h expected %h", n, key_out, key); end
        end
    endtask

    initial begin
        rst = 1'b1;
        valid_in = 1'b0;
        ciphertext_in = '0;
        key_in = '0;
        build_sbox();
        test_reset();
        test_fips_c1();
        test_fips_b();
        test_back_to_back();
        test_ignore_in_run();
        test_reset_mid_run();
        test_loopback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/aes_decrypt_core.md
AES_DECRYPT_CORE -- requirements
Module: aes_decrypt_core

Interface
REQ-001 Parameter KEY_WIDTH, default 128, key length in bits; only 128 is supported, and any other value SHALL fail elaboration.
REQ-002 Parameter DATA_WIDTH, default 128, block size in bits; fixed at 128.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 valid_in  input  1  ciphertext_in and key_in are valid this cycle.
REQ-006 ciphertext_in  input  128  block to decrypt, FIPS-197 byte order (byte 0 = bits 127:120).
REQ-007 key_in  input  128  round-10 (final) round key, the same value the encrypt core drives on key_out.
REQ-008 ready  output  1  high when a new block can be accepted.
REQ-009 plaintext_out  output  128  decrypted block.
REQ-010 key_out  output  128  recovered round-0 (cipher) key.
REQ-011 valid_out  output  1  one-cycle pulse marking plaintext_out/key_out as newly valid.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 Accept occurs on an edge where valid_in=1 and ready=1; ready SHALL be 1 in IDLE and DONE and 0 in RUN.
REQ-014 On accept: state_reg = ciphertext_in ^ key_in, key_reg = key_in, round = 10, FSM -> RUN.
REQ-015 In RUN, each edge SHALL compute prev_key = inverse key schedule of key_reg using rcon[round] (01,02,04,08,10,20,40,80,1b,36 for rounds 1..10).
REQ-016 Inverse key step: w0..w3 are the words of key_reg; p3=w3^w2, p2=w2^w1, p1=w1^w0, p0=w0^SubWord(RotWord(p3))^{rcon,00,00,00}.
REQ-017 In RUN with round>1: state_reg = InvMixColumns(InvSubBytes(InvShiftRows(state_reg)) ^ prev_key), key_reg = prev_key, round decrements.
REQ-018 In RUN with round=1: plaintext_out = InvSubBytes(InvShiftRows(state_reg)) ^ prev_key with no InvMixColumns, key_out = prev_key, FSM -> DONE.
REQ-019 Latency: with accept at edge T, valid_out SHALL be 1 in the cycle after edge T+10 and 0 otherwise.
REQ-020 DONE lasts one cycle; valid_out = (FSM==DONE). If no accept occurs in DONE, FSM -> IDLE.
REQ-021 Accept in DONE SHALL start a new block, giving back-to-back throughput of one block per 11 cycles.
REQ-022 valid_in while in RUN SHALL be ignored: no state change and no buffering.
REQ-023 plaintext_out and key_out SHALL hold their values until the next completion or reset.
REQ-024 All GF(2^8) arithmetic is mod x^8+x^4+x^3+x+1; InvMixColumns uses coefficients {0e,0b,0d,09}.
REQ-025 InvSubBytes SHALL use the inverse S-box; the key step SHALL use the forward S-box.

Reset
REQ-026 When rst=1 at an edge: FSM=IDLE, round=0, state_reg=0, key_reg=0, plaintext_out=0, key_out=0, valid_out=0; ready SHALL be 1 in the following cycle.
REQ-027 Reset SHALL take priority over accept and over RUN progress.
REQ-028 Reset asserted mid-RUN SHALL abort the block, and no valid_out pulse SHALL be produced for it.

Structure
REQ-029 Package aes_pkg SHALL hold: the FSM state enum, the rcon table, NUM_ROUNDS=10, the GF multiply functions (xtime, mul09/0b/0d/0e), and the forward and inverse S-box tables.
REQ-030 One sub-module, aes_inv_round, SHALL implement combinational InvShiftRows, InvSubBytes, AddRoundKey and optional InvMixColumns (last_round input).
REQ-031 Key-reverse logic and the FSM SHALL reside in aes_decrypt_core.

Verification
REQ-032 FIPS-197 C.1: ct=69c4e0d86a7b0430d8cdb78070b4c55a, key_in=13111d7fe3944a17f307a78b4d2b30c5 -> plaintext_out=00112233445566778899aabbccddeeff, key_out=000102030405060708090a0b0c0d0e0f, valid_out exactly 11 cycles after accept.
REQ-033 FIPS-197 App. B: ct=3925841d02dc09fbdc118597196a0b32, key_in=d014f9a8c9ee2589e13f0cc8b6630ca6 -> plaintext_out=3243f6a8885a308d313198a2e0370734, key_out=2b7e151628aed2a6abf7158809cf4f3c.
REQ-034 Back-to-back: B vector accepted in the DONE cycle of C.1 -> two valid_out pulses 11 cycles apart, both results correct.
REQ-035 valid_in held high with a different ct during RUN -> ready=0, first result unchanged, second block not accepted until DONE.
REQ-036 rst pulsed at round 5 -> next cycle all outputs 0, ready=1, no valid_out; a following C.1 run decrypts correctly.
REQ-037 Loopback: encrypt core ciphertext_out/key_out fed to this block for 1000 random pt/key pairs -> plaintext_out equals original pt and key_out equals original key.
